dmem_arbiter: RTL and testbench

Arbitrates the single-ported data memory (RAMDualPort, 2K words) between the CPU load/store path (port 0) and a DMA/debug requester (port 1). Each port issues a virtual byte address, which is decoded against the 8 KB data segment. The block applies round-robin priority, generates the memory strobes and returns read data with a per-port response handshake. It sits between ControlUnit/ALU (CPU side) and `dataMem`, replacing MemDecoder's direct connection.

---
 rtl/mips32_pkg.sv | 20 ++
 rtl/dmem_arbiter_seg_decoder.sv | 25 ++
 rtl/dmem_arbiter.sv | 141 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips32_pkg.sv
// Shared constants for the data-memory path: FSM encodings, segment base, port ids.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mips32_pkg;

  // Arbiter FSM encodings
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RESP = 1'b1;

  // Virtual base of the 8 KB data segment
  localparam logic [31:0] SEG_BASE_DEFAULT = 32'h1001_0000;

  // Requester identities (also the index into req/gnt/rvalid)
  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

  // Saturation ceiling of the contention counter
  localparam logic [15:0] CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/dmem_arbiter_seg_decoder.sv
// Maps a virtual byte address onto a physical word address inside the data segment.
// Latency: combinational.
// Backpressure: none; pure function of the input address.
module seg_decoder
  import mips32_pkg::*;
#(
  parameter logic [31:0] SEG_BASE  = SEG_BASE_DEFAULT,
  parameter int          SEG_WORDS = 2048,
  parameter int          AW        = 11
) (
  input  logic [31:0]   virt,
  output logic [AW-1:0] phys,
  output logic          invalid
);

  localparam logic [31:0] SEG_BYTES = 32'(SEG_WORDS * 4);

  logic [31:0] offset;

  // Unsigned subtraction: addresses below the base wrap to huge offsets and fail the range test
  assign offset  = virt - SEG_BASE;
  assign phys    = offset[AW+1:2];
  assign invalid = (offset >= SEG_BYTES) || (virt[1:0] != 2'b00);

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the single-ported data RAM between the CPU (port 0) and DMA (port 1).
// Latency: gnt and strobes combinational from req in IDLE; rvalid/rdata one cycle later.
// Backpressure: a losing or busy port keeps req high until its gnt; one transaction per two cycles.
module dmem_arbiter
  import mips32_pkg::*;
#(
  parameter logic [31:0] SEG_BASE  = SEG_BASE_DEFAULT,
  parameter int          SEG_WORDS = 2048,
  parameter int          AW        = 11
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    req,
  input  logic [1:0]    we,
  input  logic [31:0]   addr0,
  input  logic [31:0]   addr1,
  input  logic [31:0]   wdata0,
  input  logic [31:0]   wdata1,
  output logic [1:0]    gnt,
  output logic [1:0]    rvalid,
  output logic [1:0]    err,
  output logic [31:0]   rdata,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_din,
  output logic          mem_str,
  output logic          mem_ld,
  input  logic [31:0]   mem_dout,
  output logic [15:0]   conflict_cnt
);

  logic [0:0]    state;
  logic          last;
  logic          respPort;
  logic          respFault;
  logic          respLoad;
  logic [15:0]   cnt;

  logic          selPort;
  logic [31:0]   selAddr;
  logic [31:0]   selWdata;
  logic          selWe;
  logic [AW-1:0] selPhys;
  logic          selInvalid;
  logic          grantNow;
  logic          respNow;
  logic          denied;

  // Pick the winner: on a tie the port that did not win last time, otherwise the lone requester
  always_comb begin
    selPort = PORT_CPU;
    case (req)
      2'b11:   selPort = ~last;
      2'b10:   selPort = PORT_DMA;
      default: selPort = PORT_CPU;
    endcase
    selAddr  = (selPort == PORT_DMA) ? addr1 : addr0;
    selWdata = (selPort == PORT_DMA) ? wdata1 : wdata0;
    selWe    = we[selPort];
  end

  seg_decoder #(
    .SEG_BASE  (SEG_BASE),
    .SEG_WORDS (SEG_WORDS),
    .AW        (AW)
  ) uDecoder (
    .virt    (selAddr),
    .phys    (selPhys),
    .invalid (selInvalid)
  );

  // Reset masks every output so an aborted transaction never shows a grant or response
  assign grantNow = !rst && (state == IDLE) && (req != 2'b00);
  assign respNow  = !rst && (state == RESP);

  // Grant-cycle outputs: one-hot grant plus the RAM strobes for an in-segment access
  always_comb begin
    gnt      = 2'b00;
    mem_str  = 1'b0;
    mem_ld   = 1'b0;
    mem_addr = '0;
    mem_din  = '0;
    if (grantNow) begin
      gnt      = (selPort == PORT_DMA) ? 2'b10 : 2'b01;
      mem_addr = selPhys;
      if (!selInvalid) begin
        mem_str = selWe;
        mem_ld  = !selWe;
        mem_din = selWe ? selWdata : 32'h0;
      end
    end
  end

  // Response-cycle outputs: pulse rvalid to the owner, forward RAM data only for a good load
  always_comb begin
    rvalid = 2'b00;
    err    = 2'b00;
    rdata  = 32'h0;
    if (respNow) begin
      rvalid = (respPort == PORT_DMA) ? 2'b10 : 2'b01;
      err    = respFault ? rvalid : 2'b00;
      rdata  = (respLoad && !respFault) ? mem_dout : 32'h0;
    end
  end

  assign denied       = ((req & ~gnt) != 2'b00);
  assign conflict_cnt = rst ? 16'h0 : cnt;

  // Two-state transaction FSM; the grant cycle records who owns the response and its outcome
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      last      <= PORT_DMA;
      respPort  <= PORT_CPU;
      respFault <= 1'b0;
      respLoad  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req != 2'b00) begin
            state     <= RESP;
            last      <= selPort;
            respPort  <= selPort;
            respFault <= selInvalid;
            respLoad  <= !selWe;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Count cycles where some requesting port went without a grant, sticking at the ceiling
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= 16'h0;
    end else if (denied && (cnt != CNT_MAX)) begin
      cnt <= cnt + 16'h1;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized two-port traffic.
// Latency: expects gnt in the request cycle and the response one cycle later.
// Backpressure: requesters hold their request until granted, then drop or re-issue.
module tb_dmem_arbiter;

  localparam logic [31:0] BASE = 32'h1001_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req;
  logic [1:0]  we;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic [1:0]  gnt, rvalid, err;
  logic [31:0] rdata;
  logic [10:0] mem_addr;
  logic [31:0] mem_din;
  logic        mem_str, mem_ld;
  logic [31:0] mem_dout = 32'h0;
  logic [15:0] conflict_cnt;

  int nChecks = 0;
  int nFails  = 0;

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .we           (we),
    .addr0        (addr0),
    .addr1        (addr1),
    .wdata0       (wdata0),
    .wdata1       (wdata1),
    .gnt          (gnt),
    .rvalid       (rvalid),
    .err          (err),
    .rdata        (rdata),
    .mem_addr     (mem_addr),
    .mem_din      (mem_din),
    .mem_str      (mem_str),
    .mem_ld       (mem_ld),
    .mem_dout     (mem_dout),
    .conflict_cnt (conflict_cnt)
  );

  // Environment RAM: write on store strobe, registered read on load strobe
  logic [31:0] ram [0:2047];
  initial for (int i = 0; i < 2048; i++) ram[i] = 32'h0;
  always @(posedge clk) begin
    if (mem_str) ram[mem_addr] <= mem_din;
    if (mem_ld)  mem_dout <= ram[mem_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: transaction-level view ----------------
  bit          mBusy, mPort, mFault, mLast;
  logic [31:0] mData;
  int          mCnt;
  logic [31:0] mMem [0:2047];
  initial for (int i = 0; i < 2048; i++) mMem[i] = 32'h0;

  logic [1:0]  eG, eRv, eErr;
  logic [31:0] eRd, eA, eDin;
  logic [10:0] eW;
  bit          eStr, eLd, eOk;
  int          eP;

  always @(negedge clk) begin
    eG = 2'b00; eRv = 2'b00; eErr = 2'b00; eRd = 32'h0;
    eStr = 0; eLd = 0; eW = 11'h0; eDin = 32'h0;
    if (rst) begin
      chk("rst gnt",    32'(gnt), 0);
      chk("rst rvalid", 32'(rvalid), 0);
      chk("rst err",    32'(err), 0);
      chk("rst rdata",  rdata, 0);
      chk("rst str",    32'(mem_str), 0);
      chk("rst ld",     32'(mem_ld), 0);
      chk("rst maddr",  32'(mem_addr), 0);
      chk("rst mdin",   mem_din, 0);
      chk("rst cnt",    32'(conflict_cnt), 0);
      mBusy = 0; mLast = 1; mCnt = 0;
    end else begin
      if (mBusy) begin
        eRv  = mPort ? 2'b10 : 2'b01;
        eErr = mFault ? eRv : 2'b00;
        eRd  = mData;
        mBusy = 0;
      end else if (req != 2'b00) begin
        if (req == 2'b11) eP = mLast ? 0 : 1;
        else              eP = req[1] ? 1 : 0;
        eA  = (eP == 1) ? addr1 : addr0;
        eOk = (eA >= BASE) && (eA <= BASE + 32'd8188) && (eA % 4 == 0);
        eG  = (eP == 1) ? 2'b10 : 2'b01;
        mData = 32'h0;
        if (eOk) begin
          eW = 11'((eA - BASE) / 4);
          if (we[eP]) begin
            eStr = 1;
            eDin = (eP == 1) ? wdata1 : wdata0;
            mMem[eW] = eDin;
          end else begin
            eLd = 1;
            mData = mMem[eW];
          end
        end
        mBusy = 1; mPort = (eP == 1); mFault = !eOk; mLast = (eP == 1);
      end
      chk("gnt",    32'(gnt), 32'(eG));
      chk("rvalid", 32'(rvalid), 32'(eRv));
      chk("err",    32'(err), 32'(eErr));
      chk("rdata",  rdata, eRd);
      chk("mem_str", 32'(mem_str), 32'(eStr));
      chk("mem_ld",  32'(mem_ld), 32'(eLd));
      if (eStr || eLd) chk("mem_addr", 32'(mem_addr), 32'(eW));
      if (eStr)        chk("mem_din", mem_din, eDin);
      chk("conflict_cnt", 32'(conflict_cnt), 32'(mCnt));
      if (((req & ~eG) != 2'b00) && mCnt < 65535) mCnt++;
    end
  end

  // ---------------- stimulus ----------------
  bit act [2];

  function automatic logic [31:0] randAddr();
    case ($urandom_range(0, 9))
      0:       return 32'h1001_1FFC;
      1:       return 32'h1001_2000;
      2:       return 32'h1000_FFFC;
      3:       return BASE + 32'($urandom_range(0, 31) * 4 + $urandom_range(1, 3));
      default: return BASE + 32'($urandom_range(0, 31) * 4);
    endcase
  endfunction

  task automatic newReq(input int p);
    req[p] = 1'b1;
    we[p]  = 1'($urandom_range(0, 1));
    if (p == 0) begin addr0 = randAddr(); wdata0 = $urandom; end
    else        begin addr1 = randAddr(); wdata1 = $urandom; end
    act[p] = 1;
  endtask

  // One transaction from an idle arbiter; captures what the grant and response cycles showed
  task automatic txn(input int p, input bit w, input logic [31:0] a, input logic [31:0] d,
                     output bit granted, output bit sStr, output bit sLd,
                     output logic [10:0] sAddr, output logic [31:0] sDin,
                     output logic [1:0] rv, output logic [1:0] er, output logic [31:0] rd);
    req[p] = 1'b1; we[p] = w;
    if (p == 0) begin addr0 = a; wdata0 = d; end
    else        begin addr1 = a; wdata1 = d; end
    granted = 0; sStr = 0; sLd = 0; sAddr = 11'h0; sDin = 32'h0;
    for (int i = 0; i < 8 && !granted; i++) begin
      @(negedge clk);
      if (gnt[p]) begin
        granted = 1; sStr = mem_str; sLd = mem_ld; sAddr = mem_addr; sDin = mem_din;
      end
      @(posedge clk); #1;
    end
    req[p] = 1'b0;
    @(negedge clk);
    rv = rvalid; er = err; rd = rdata;
    @(posedge clk); #1;
  endtask

  bit          tg, tStr, tLd;
  logic [10:0] tAddr;
  logic [31:0] tDin, tRd;
  logic [1:0]  tRv, tEr, g;
  logic [1:0]  tieG [7];
  logic [15:0] tieC [7];
  logic [31:0] faultAddrs [3];

  initial begin
    rst = 1; req = 2'b00; we = 2'b00;
    addr0 = BASE; addr1 = BASE; wdata0 = 0; wdata1 = 0;
    repeat (2) @(posedge clk);
    #1;

    // Tie after reset: both ports requesting loads continuously from reset release
    req = 2'b11; we = 2'b00; addr0 = BASE + 32'h20; addr1 = BASE + 32'h40;
    @(posedge clk); #1;
    rst = 0;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk); tieG[c] = gnt; tieC[c] = conflict_cnt;
      @(posedge clk); #1;
    end
    req = 2'b00;
    chk("tie c0", 32'(tieG[0]), 32'h1);
    chk("tie c1", 32'(tieG[1]), 32'h0);
    chk("tie c2", 32'(tieG[2]), 32'h2);
    chk("tie c4", 32'(tieG[4]), 32'h1);
    chk("tie c6", 32'(tieG[6]), 32'h2);
    // denials in cycles 0,1,2 become visible in cycle 3
    chk("tie cnt c3", 32'(tieC[3]), 32'd3);
    chk("tie cnt c6", 32'(tieC[6]), 32'd6);
    repeat (2) begin @(posedge clk); #1; end

    // Single-port round trip
    txn(0, 1, 32'h1001_0010, 32'hDEAD_BEEF, tg, tStr, tLd, tAddr, tDin, tRv, tEr, tRd);
    chk("rt st granted", 32'(tg), 1);
    chk("rt st strobe",  32'(tStr), 1);
    chk("rt st addr",    32'(tAddr), 4);
    chk("rt st din",     tDin, 32'hDEAD_BEEF);
    txn(0, 0, 32'h1001_0010, 32'h0, tg, tStr, tLd, tAddr, tDin, tRv, tEr, tRd);
    chk("rt ld rvalid", 32'(tRv), 32'h1);
    chk("rt ld rdata",  tRd, 32'hDEAD_BEEF);
    chk("rt ld err",    32'(tEr), 0);

    // Segment faults on port 1
    faultAddrs[0] = 32'h1001_2000; faultAddrs[1] = 32'h1000_FFFC; faultAddrs[2] = 32'h1001_0002;
    for (int i = 0; i < 3; i++) begin
      txn(1, 0, faultAddrs[i], 32'h0, tg, tStr, tLd, tAddr, tDin, tRv, tEr, tRd);
      chk("fault granted", 32'(tg), 1);
      chk("fault no ld",   32'(tLd), 0);
      chk("fault rvalid",  32'(tRv), 32'h2);
      chk("fault err",     32'(tEr), 32'h2);
      chk("fault rdata",   tRd, 0);
    end

    // Top-of-segment boundary
    txn(1, 1, 32'h1001_1FFC, 32'h1234_5678, tg, tStr, tLd, tAddr, tDin, tRv, tEr, tRd);
    chk("top st strobe", 32'(tStr), 1);
    chk("top st addr",   32'(tAddr), 2047);
    chk("top st err",    32'(tEr), 0);
    txn(1, 0, 32'h1001_1FFC, 32'h0, tg, tStr, tLd, tAddr, tDin, tRv, tEr, tRd);
    chk("top ld rdata",  tRd, 32'h1234_5678);
    chk("top ld err",    32'(tEr), 0);

    // Reset in the response cycle of a port-0 load (port 0 then owns last, so a tie would go to 1)
    req = 2'b01; we = 2'b00; addr0 = 32'h1001_0010;
    @(negedge clk); chk("abort gnt", 32'(gnt), 32'h1);
    @(posedge clk); #1;
    rst = 1; req = 2'b00;
    @(negedge clk);
    chk("abort rvalid", 32'(rvalid), 0);
    chk("abort rdata",  rdata, 0);
    chk("abort cnt",    32'(conflict_cnt), 0);
    @(posedge clk); #1;
    rst = 0; req = 2'b11; addr1 = BASE;
    @(negedge clk); chk("abort tie", 32'(gnt), 32'h1);
    @(posedge clk); #1;
    req = 2'b00;
    repeat (2) begin @(posedge clk); #1; end

    // Randomized two-port traffic with occasional resets
    act[0] = 0; act[1] = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk); g = gnt;
      @(posedge clk); #1;
      rst = ($urandom_range(0, 63) == 0);
      for (int p = 0; p < 2; p++) begin
        if (act[p] && g[p]) begin
          if ($urandom_range(0, 1) == 0) begin req[p] = 1'b0; act[p] = 0; end
          else newReq(p);
        end else if (!act[p] && $urandom_range(0, 2) == 0) begin
          newReq(p);
        end
      end
    end
    req = 2'b00; rst = 1;
    @(posedge clk); #1;
    rst = 0;

    // Counter saturation under continuous contention
    req = 2'b11; we = 2'b00; addr0 = BASE; addr1 = BASE + 32'h4;
    repeat (70000) @(posedge clk);
    #1;
    @(negedge clk); chk("cnt saturated", 32'(conflict_cnt), 32'h0000_FFFF);
    @(posedge clk); #1;
    req = 2'b00;
    repeat (3) begin @(posedge clk); #1; end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

  initial begin
    #2_000_000;
    nFails++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
